// File: rtl/sip_dot_pipe_if.sv
// Beat/result handshake bundle for the 2b x 2b slice dot-product pipe.
// master drives beats and result ready; slave is the pipe.
interface sip_dot_pipe_if #(
   parameter int N_DOT    = 32,
   parameter int BITS_ACC = 24
);
   logic                       i_Valid;
   logic                       o_Ready;
   logic [2*N_DOT-1:0]         i_Act;
   logic [2*N_DOT-1:0]         i_Weight;
   logic                       i_SignI;
   logic                       i_SignW;
   logic [3:0]                 i_Shift;
   logic                       i_Last;
   logic                       o_Valid;
   logic                       i_Ready;
   logic signed [BITS_ACC-1:0] o_Result;

   modport master (
      output i_Valid, i_Act, i_Weight, i_SignI, i_SignW,
      output i_Shift, i_Last, i_Ready,
      input  o_Ready, o_Valid, o_Result
   );

   modport slave (
      input  i_Valid, i_Act, i_Weight, i_SignI, i_SignW,
      input  i_Shift, i_Last, i_Ready,
      output o_Ready, o_Valid, o_Result
   );
endinterface

// File: rtl/sip_dot_pipe.sv
// Three-stage slice dot product: multiply, tree reduce, shift-accumulate.
// Define SIP_DOT_PIPE_SAT_EN to clamp the accumulator instead of wrapping.
module sip_dot_pipe #(
   parameter int N_DOT         = 32,
   parameter int BITS_PARALLEL = 2,
   parameter int BITS_ACC      = 24
) (
   input logic          i_CLK,
   input logic          i_RST,
   sip_dot_pipe_if.slave bus
);
   localparam int BITS_MUL = 5;
   localparam int BITS_SUM = BITS_MUL + $clog2(N_DOT);

   logic en;

   logic signed [BITS_MUL-1:0] prod1_d [N_DOT];
   logic signed [BITS_MUL-1:0] prod1_q [N_DOT];
   logic                       v1_q, last1_q;
   logic [3:0]                 shift1_q;

   logic signed [BITS_SUM-1:0] sum2_d, sum2_q;
   logic                       v2_q, last2_q;
   logic [3:0]                 shift2_q;

   logic signed [BITS_ACC-1:0] acc_d, acc_q;
   logic signed [BITS_ACC-1:0] result_q;
   logic                       valid_q;

   function automatic logic signed [BITS_MUL-1:0] mul2(
      input logic [BITS_PARALLEL-1:0] a,
      input logic [BITS_PARALLEL-1:0] w,
      input logic                     sa,
      input logic                     sw
   );
      logic signed [BITS_MUL-1:0] ae, we;
      ae = {{(BITS_MUL-BITS_PARALLEL){sa & a[BITS_PARALLEL-1]}}, a};
      we = {{(BITS_MUL-BITS_PARALLEL){sw & w[BITS_PARALLEL-1]}}, w};
      return ae * we;
   endfunction

   // whole pipe advances together; a held result freezes every stage
   assign en          = !valid_q | bus.i_Ready;
   assign bus.o_Ready = en;
   assign bus.o_Valid = valid_q;
   assign bus.o_Result = result_q;

   // per-lane sign-extended slice products
   always_comb begin
      for (int i = 0; i < N_DOT; i++) begin
         prod1_d[i] = mul2(bus.i_Act[BITS_PARALLEL*i +: BITS_PARALLEL],
                           bus.i_Weight[BITS_PARALLEL*i +: BITS_PARALLEL],
                           bus.i_SignI, bus.i_SignW);
      end
   end

   // S1: capture products and beat side-band
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         v1_q     <= 1'b0;
         last1_q  <= 1'b0;
         shift1_q <= '0;
         for (int i = 0; i < N_DOT; i++) prod1_q[i] <= '0;
      end else if (en) begin
         v1_q     <= bus.i_Valid;
         last1_q  <= bus.i_Last;
         shift1_q <= bus.i_Shift;
         for (int i = 0; i < N_DOT; i++) prod1_q[i] <= prod1_d[i];
      end
   end

   // exact reduction of all lane products, wide enough never to overflow
   always_comb begin
      sum2_d = '0;
      for (int i = 0; i < N_DOT; i++) begin
         sum2_d = sum2_d + BITS_SUM'(prod1_q[i]);
      end
   end

   // S2: capture the tree sum
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         v2_q     <= 1'b0;
         last2_q  <= 1'b0;
         shift2_q <= '0;
         sum2_q   <= '0;
      end else if (en) begin
         v2_q     <= v1_q;
         last2_q  <= last1_q;
         shift2_q <= shift1_q;
         sum2_q   <= sum2_d;
      end
   end

`ifdef SIP_DOT_PIPE_SAT_EN
   localparam int W = BITS_ACC + 16;
   logic signed [W-1:0] wide;

   // widened accumulate, then clamp to the signed accumulator range
   always_comb begin
      wide = W'(acc_q) + (W'(sum2_q) <<< shift2_q);
      if (wide[W-1:BITS_ACC-1] == {(W-BITS_ACC+1){wide[W-1]}}) begin
         acc_d = wide[BITS_ACC-1:0];
      end else begin
         acc_d = {wide[W-1], {(BITS_ACC-1){~wide[W-1]}}};
      end
   end
`else
   logic signed [BITS_ACC-1:0] addend;

   // modular accumulate; shifted-out bits above the accumulator drop
   always_comb begin
      addend = BITS_ACC'(sum2_q) <<< shift2_q;
      acc_d  = acc_q + addend;
   end
`endif

   // S3: accumulate, publish on last beat, hold while downstream stalls
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         acc_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else if (en) begin
         if (v2_q && last2_q) begin
            result_q <= acc_d;
            valid_q  <= 1'b1;
            acc_q    <= '0;
         end else begin
            if (v2_q) acc_q <= acc_d;
            valid_q <= valid_q & ~bus.i_Ready;
         end
      end
   end
endmodule

// File: tb/tb_sip_dot_pipe.sv
// Scoreboard bench for sip_dot_pipe: a 24-bit and a 12-bit accumulator
// instance share one stimulus stream and are checked against a model.
module tb_sip_dot_pipe;
   localparam int N  = 32;
   localparam int B0 = 24;
   localparam int B1 = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic           valid = 1'b0;
   logic [2*N-1:0] act = '0;
   logic [2*N-1:0] wgt = '0;
   logic           si = 1'b0;
   logic           sw = 1'b0;
   logic [3:0]     sh = '0;
   logic           last = 1'b0;
   logic           rdy = 1'b1;
   int             mode = 0;

   int checks = 0;
   int errors = 0;
   int outs0 = 0;
   int outs1 = 0;

   longint acc0 = 0;
   longint acc1 = 0;
   longint q0[$];
   longint q1[$];

   sip_dot_pipe_if #(.N_DOT(N), .BITS_ACC(B0)) bus0 ();
   sip_dot_pipe_if #(.N_DOT(N), .BITS_ACC(B1)) bus1 ();

   assign bus0.i_Valid = valid;  assign bus1.i_Valid = valid;
   assign bus0.i_Act = act;      assign bus1.i_Act = act;
   assign bus0.i_Weight = wgt;   assign bus1.i_Weight = wgt;
   assign bus0.i_SignI = si;     assign bus1.i_SignI = si;
   assign bus0.i_SignW = sw;     assign bus1.i_SignW = sw;
   assign bus0.i_Shift = sh;     assign bus1.i_Shift = sh;
   assign bus0.i_Last = last;    assign bus1.i_Last = last;
   assign bus0.i_Ready = rdy;    assign bus1.i_Ready = rdy;

   sip_dot_pipe #(.N_DOT(N), .BITS_PARALLEL(2), .BITS_ACC(B0)) u0 (
      .i_CLK(clk), .i_RST(rst), .bus(bus0.slave)
   );
   sip_dot_pipe #(.N_DOT(N), .BITS_PARALLEL(2), .BITS_ACC(B1)) u1 (
      .i_CLK(clk), .i_RST(rst), .bus(bus1.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // downstream ready pattern, changed well away from both edges
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (mode)
            0: rdy = 1'b1;
            1: rdy = ($urandom_range(0, 3) != 0);
            default: rdy = 1'b0;
         endcase
      end
   end

   function automatic int slice_val(input logic [1:0] x, input logic s);
      if (s && x[1]) return int'(x) - 4;
      return int'(x);
   endfunction

   function automatic longint beat_sum(input logic [2*N-1:0] a,
                                       input logic [2*N-1:0] w,
                                       input logic sa, input logic sb);
      longint s;
      logic [1:0] x, y;
      s = 0;
      for (int i = 0; i < N; i++) begin
         x = a[2*i +: 2];
         y = w[2*i +: 2];
         s += longint'(slice_val(x, sa) * slice_val(y, sb));
      end
      return s;
   endfunction

   function automatic longint fold(input longint v, input int b);
      longint m;
      m = 64'sd1 <<< b;
`ifdef SIP_DOT_PIPE_SAT_EN
      if (v > m/2 - 1) return m/2 - 1;
      if (v < -(m/2)) return -(m/2);
      return v;
`else
      v = v % m;
      if (v < 0) v += m;
      if (v >= m/2) v -= m;
      return v;
`endif
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic send(input logic [2*N-1:0] a, input logic [2*N-1:0] w,
                       input logic sa, input logic sb,
                       input logic [3:0] s, input logic l);
      int n;
      longint t;
      n = 0;
      @(negedge clk);
      valid = 1'b1; act = a; wgt = w; si = sa; sw = sb; sh = s; last = l;
      while (!bus0.o_Ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         check("send_timeout", 1, 0);
      end else begin
         @(posedge clk);
         t = beat_sum(a, w, sa, sb) <<< s;
         acc0 = fold(acc0 + t, B0);
         acc1 = fold(acc1 + t, B1);
         if (l) begin
            q0.push_back(acc0);
            q1.push_back(acc1);
            acc0 = 0;
            acc1 = 0;
         end
      end
      #1 valid = 1'b0;
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus0.o_Valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("wait_out_timeout", 1, 0);
   endtask

   task automatic four_beat();
      logic [1:0] alo, ahi, wlo, whi;
      alo = 2'b11; ahi = 2'b01; wlo = 2'b01; whi = 2'b10;
      send({N{alo}}, {N{wlo}}, 1'b0, 1'b0, 4'd0, 1'b0);
      send({N{alo}}, {N{whi}}, 1'b0, 1'b1, 4'd2, 1'b0);
      send({N{ahi}}, {N{wlo}}, 1'b1, 1'b0, 4'd2, 1'b0);
      send({N{ahi}}, {N{whi}}, 1'b1, 1'b1, 4'd4, 1'b1);
   endtask

   // scoreboard monitors: a transfer happens at the next rising edge
   always @(negedge clk) begin
      if (!rst && bus0.o_Valid && bus0.i_Ready) begin
         outs0++;
         if (q0.size() == 0) check("unexpected_out0", 1, 0);
         else check("result0", longint'(bus0.o_Result), q0.pop_front());
      end
   end

   always @(negedge clk) begin
      if (!rst && bus1.o_Valid && bus1.i_Ready) begin
         outs1++;
         if (q1.size() == 0) check("unexpected_out1", 1, 0);
         else check("result1", longint'(bus1.o_Result), q1.pop_front());
      end
   end

   initial begin
      logic [1:0] three, two, one;
      int base;
      three = 2'b11; two = 2'b10; one = 2'b01;

      repeat (2) @(negedge clk);
      check("rst_valid0", longint'(bus0.o_Valid), 0);
      check("rst_result0", longint'(bus0.o_Result), 0);
      check("rst_ready0", longint'(bus0.o_Ready), 1);
      check("rst_valid1", longint'(bus1.o_Valid), 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", longint'(bus0.o_Ready), 1);

      send({N{three}}, {N{three}}, 1'b0, 1'b0, 4'd0, 1'b1);
      @(negedge clk);
      check("lat_t0", longint'(bus0.o_Valid), 0);
      @(negedge clk);
      check("lat_t1", longint'(bus0.o_Valid), 0);
      @(negedge clk);
      check("lat_t2", longint'(bus0.o_Valid), 1);
      check("unsigned288", longint'(bus0.o_Result), 288);

      send({N{two}}, {N{one}}, 1'b1, 1'b0, 4'd0, 1'b1);
      wait_out();
      check("sxu0", longint'(bus0.o_Result), -64);
      check("sxu1", longint'(bus1.o_Result), -64);

      four_beat();
      wait_out();
      check("dot4b0", longint'(bus0.o_Result), -1568);
      check("dot4b1", longint'(bus1.o_Result), -1568);

      send({N{three}}, {N{three}}, 1'b0, 1'b0, 4'd4, 1'b1);
      wait_out();
      check("ovf24", longint'(bus0.o_Result), 4608);
`ifdef SIP_DOT_PIPE_SAT_EN
      check("ovf12", longint'(bus1.o_Result), 2047);
`else
      check("ovf12", longint'(bus1.o_Result), 512);
`endif

      mode = 2;
      repeat (2) @(posedge clk);
      send({N{three}}, {N{three}}, 1'b0, 1'b0, 4'd0, 1'b1);
      send({N{three}}, {N{three}}, 1'b0, 1'b0, 4'd0, 1'b1);
      wait_out();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_ready", longint'(bus0.o_Ready), 0);
         check("bp_valid", longint'(bus0.o_Valid), 1);
         check("bp_result", longint'(bus0.o_Result), 288);
      end
      base = outs0;
      mode = 0;
      repeat (6) @(negedge clk);
      check("bp_count", longint'(outs0), longint'(base + 2));

      send({N{three}}, {N{one}}, 1'b0, 1'b0, 4'd0, 1'b0);
      send({N{two}}, {N{two}}, 1'b1, 1'b1, 4'd3, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      acc0 = 0;
      acc1 = 0;
      #1;
      check("mid_rst_valid", longint'(bus0.o_Valid), 0);
      @(negedge clk);
      check("mid_rst_valid_b", longint'(bus1.o_Valid), 0);
      rst = 1'b0;
      four_beat();
      wait_out();
      check("rst_replay0", longint'(bus0.o_Result), -1568);
      check("rst_replay1", longint'(bus1.o_Result), -1568);

      mode = 1;
      for (int g = 0; g < 60; g++) begin
         int len;
         len = $urandom_range(1, 4);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send({$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom), 1'($urandom),
                 4'($urandom_range(0, 15)), b == len - 1);
         end
      end

      mode = 0;
      for (int k = 0; k < 100 && (q0.size() != 0 || q1.size() != 0); k++) begin
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check("drain0", longint'(q0.size()), 0);
      check("drain1", longint'(q1.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sip_dot_pipe.md
# sip_dot_pipe

Parametrised, pipelined successor to the combinational 2b×2b dot-product slice and its adder. Each accepted beat carries one 2-bit activation slice and one 2-bit weight slice per lane. Per beat, the block forms N_DOT signed/unsigned products, reduces them in a registered adder tree, and shift-accumulates across beats. Multi-bit (4b/8b/mixed) dot products are therefore built from bit-slice passes. It sits between the slice-select/operand fetch logic and the output-partial-sum buffer, with a valid/ready handshake on both sides.

## Interface
- `N_DOT`, 32: lanes per beat; power of two, 2..64.
- `BITS_PARALLEL`, 2: slice width per operand; fixed at 2, exposed for width derivation only.
- `BITS_ACC`, 24: accumulator and result width; at least `BITS_SUM`+8.
- Derived, not overridable: `BITS_MUL`=5; `BITS_SUM`=`BITS_MUL`+clog2(`N_DOT`).
- `i_CLK`  in  1  clock; all state updates on rising edge.
- `i_RST`  in  1  asynchronous, active-high reset.
- `i_Valid`  in  1  beat offered.
- `o_Ready`  out  1  beat accepted on an edge where `i_Valid` & `o_Ready`.
- `i_Act`  in  N_DOT*2  activation slices; lane i is `[2i+1:2i]`.
- `i_Weight`  in  N_DOT*2  weight slices, same packing.
- `i_SignI`, `i_SignW`  in  1 each  slice is two's-complement (1) or unsigned (0); applies to all lanes of the beat.
- `i_Shift`  in  4  left-shift applied to this beat's tree sum before accumulation.
- `i_Last`  in  1  final beat of the current dot product.
- `o_Valid`  out  1  result available.
- `i_Ready`  in  1  downstream accepts result on an edge where `o_Valid` & `i_Ready`.
- `o_Result`  out  BITS_ACC  signed accumulated dot product.

## Operation
- **Global advance enable:** `en` = !`o_Valid` | `i_Ready`. `o_Ready` = `en`, combinational. Every stage register updates only when `en`=1; otherwise the whole pipe is frozen.
- **S1 (multiply):**
  - Sign-extend each slice per `i_SignI`/`i_SignW`: signed range -2..1, unsigned range 0..3.
  - Register N_DOT 5-bit signed products, plus `v1`, shift, and last.
  - `v1` <= `i_Valid`. Non-valid beats are bubbles and do not touch the accumulator.
- **S2 (reduce):** register the sign-extended sum of all S1 products (`BITS_SUM` bits, exact, no overflow), plus `v2`, shift, and last.
- **S3 (accumulate):** if `v2`, compute `acc_new` = `acc` + (sign_ext(sum) <<< shift), evaluated at `BITS_ACC` width.
  - If last: `o_Result` <= `acc_new`, `o_Valid` <= 1, `acc` <= 0.
  - Otherwise: `acc` <= `acc_new`.
- `o_Valid` clears on an edge where `o_Valid` & `i_Ready` and no new last beat completes in S3. If a last beat completes on the same edge, `o_Valid` stays 1 with the new result.
- Shift bits beyond `BITS_ACC` are dropped.
- Bubbles in S2 leave `acc` unchanged. A dot product may span any number of beats, including bubbles.

## Timing
- Reset values: `o_Valid`=0, `o_Result`=0, `acc`=0, `v1`=`v2`=0, all pipeline data 0. `o_Ready`=1 during and after reset.
- Latency: a last beat accepted at edge t produces `o_Valid`=1 with its result after edge t+2, i.e. 3 register stages.
- Throughput: one beat per cycle while `i_Ready`=1.
- Stall: with `o_Valid`=1 and `i_Ready`=0, the following are held stable and nothing is accepted:
  - `o_Result`, `o_Valid`
  - `o_Ready`=0
  - the contents of all stages
- Reset mid-group discards the partial `acc` and all in-flight beats. The next accepted beat starts a new dot product.
- Inputs need only be stable at the accepting edge.

## Configuration
- **`SIP_DOT_PIPE_SAT_EN` defined:** S3 computes `acc_new` at `BITS_ACC`+16 bits, then clamps to [-2^(`BITS_ACC`-1), 2^(`BITS_ACC`-1)-1] before writing `acc`/`o_Result`. Clamping is applied on every accumulate.
- **Undefined:** two's-complement wrap-around at `BITS_ACC`.

## Test plan
- **Unsigned single beat:** all lanes `Act`=2'b11, `Weight`=2'b11, both signs 0, shift 0, last, N_DOT=32 → `o_Result`=288, `o_Valid` after 3rd edge.
- **Signed × unsigned:** `Act`=2'b10 with `SignI`=1, `Weight`=2'b01 with `SignW`=0, last → `o_Result`=-64.
- **4b×4b as four beats (act=7, weight=-7, all lanes):**
  - beat 1: (lo,lo) shift 0, signs 0/0
  - beat 2: (lo act, hi w) shift 2, signs 0/1
  - beat 3: (hi act, lo w) shift 2, signs 1/0
  - beat 4: (hi,hi) shift 4, signs 1/1, last
  - → single result -1568, no intermediate `o_Valid`.
- **Back-pressure:** two back-to-back last beats with `i_Ready`=0 for 5 cycles → first result held, `o_Ready`=0, no beat accepted. Release → results 288 then 288 in order, none lost or duplicated.
- **Overflow with `BITS_ACC`=12:** lanes 3×3, shift 4, last → 2047 with `SIP_DOT_PIPE_SAT_EN` defined; 512 (4608 mod 4096) without.
- **Reset mid-group:** assert `i_RST` after 2 of 4 beats, then replay all 4 → result equals the clean 4-beat value, `o_Valid` low throughout reset.
